addsub_arbiter: RTL and testbench
=================================

ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have port clock  input  1  rising-edge clock for all state.
REQ-003 SHALL have port clear  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports req0, req1  input  1 each  level request from requester 0/1.
REQ-005 SHALL have ports op0, op1  input  1 each  0 = add (a+b), 1 = subtract (a-b).
REQ-006 SHALL have ports a0, b0, a1, b1  input  WIDTH each  operands of requester 0/1.
REQ-007 SHALL have ports gnt0, gnt1  output  1 each  one-cycle pulse: request accepted, operands captured.
REQ-008 SHALL have ports done0, done1  output  1 each  one-cycle pulse: result for that requester valid.
REQ-009 SHALL have port result  output  WIDTH  registered sum/difference.
REQ-010 SHALL have port cout  output  1  registered carry-out of the operation.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, EXEC, DONE; IDLE -> EXEC when req0|req1 sampled high; EXEC -> DONE unconditionally; DONE -> IDLE unconditionally.
REQ-013 SHALL, on the IDLE -> EXEC edge, capture winner's op/a/b into internal registers and assert matching gnt for exactly the EXEC cycle.
REQ-014 SHALL arbitrate round-robin: single request wins; on simultaneous req0 and req1 the requester not granted last wins.
REQ-015 SHALL initialise last-granted to requester 1 so requester 0 wins the first tie after reset.
REQ-016 SHALL compute add as a+b, cin 0, and subtract as a + ~b + 1 (two's complement), both WIDTH-bit with carry-out into cout.
REQ-017 SHALL register result/cout on the EXEC -> DONE edge; gnt-to-done latency exactly 1 cycle, req-sample-to-done 2 cycles, one operation per 3 cycles.
REQ-018 SHALL assert done of the granted requester for exactly the DONE cycle; result/cout hold until the next DONE.
REQ-019 SHALL ignore req0/req1 and operand inputs in EXEC and DONE; changes there do not affect the operation in flight.
REQ-020 SHALL treat a req still high in IDLE after DONE as a new request (requester deasserts req on gnt to avoid repeat).
REQ-021 SHALL never assert gnt0 and gnt1, or done0 and done1, in the same cycle.
REQ-022 SHALL wrap modulo 2^WIDTH with no saturation; cout reflects carry (for subtract, cout=1 means no borrow).

Reset
REQ-023 SHALL, on clock edge with clear low, force IDLE, last-granted = 1, result = 0, cout = 0, gnt0/gnt1/done0/done1 = 0, busy = 0.
REQ-024 SHALL, when clear asserted mid-operation (EXEC or DONE), abandon the operation with no done pulse on that or later cycles.
REQ-025 SHALL give clear priority over all other inputs in the same cycle.

Configuration
REQ-026 SHALL, with ADDSUB_ARB_OVF_EN defined, add port ovf  output  1: registered signed overflow (operand signs per op equal, result sign differs), updated with result, reset 0.
REQ-027 SHALL, without ADDSUB_ARB_OVF_EN, omit port ovf and all its logic; remaining behaviour identical.

Verification
REQ-028 SHALL test: req0, op0=0, a0=1, b0=1 -> gnt0 next cycle, done0 one cycle later, result=2, cout=0.
REQ-029 SHALL test: req1, op1=1, a1=235, b1=35 -> gnt1, then done1, result=200, cout=1; a1=20, b1=25 -> result=0xFFFFFFFB (-5), cout=0.
REQ-030 SHALL test: req0 and req1 high together from reset, held three rounds -> grant order 0,1,0, never both gnt in one cycle.
REQ-031 SHALL test: a0=0xFFFFFFFF, b0=1, add -> result=0, cout=1; with ADDSUB_ARB_OVF_EN, a0=0x7FFFFFFF, b0=1, add -> ovf=1.
REQ-032 SHALL test: clear low during EXEC -> next cycle IDLE, busy=0, result=0, no done pulse; subsequent req0 served normally.
REQ-033 SHALL test: operands changed during EXEC -> result matches values captured at grant.

Source files
------------

// File: rtl/addsub_arbiter.sv
// addsub_arbiter: round-robin arbiter for two requesters sharing one registered add/subtract unit.
// Defining ADDSUB_ARB_OVF_EN adds the registered signed-overflow output 'ovf'.
module addsub_arbiter #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             req0,
   input  logic             req1,
   input  logic             op0,
   input  logic             op1,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             done0,
   output logic             done1,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             busy
`ifdef ADDSUB_ARB_OVF_EN
   ,
   output logic             ovf
`endif
);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t           state;
   logic             last_gnt;
   logic             cur_id;
   logic             cur_op;
   logic [WIDTH-1:0] cur_a;
   logic [WIDTH-1:0] cur_b;
   logic             pick1;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum;

   // Requester 1 wins when alone, or on a tie when requester 0 was granted last;
   // subtract reuses the adder as a + ~b + 1.
   always_comb begin
      pick1 = req1 & (~req0 | ~last_gnt);
      b_eff = cur_op ? ~cur_b : cur_b;
      sum   = {1'b0, cur_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cur_op};
      busy  = (state != IDLE);
   end

   always_ff @(posedge clock) begin
      if (!clear) begin
         state    <= IDLE;
         last_gnt <= 1'b1;
         cur_id   <= 1'b0;
         cur_op   <= 1'b0;
         cur_a    <= '0;
         cur_b    <= '0;
         result   <= '0;
         cout     <= 1'b0;
         gnt0     <= 1'b0;
         gnt1     <= 1'b0;
         done0    <= 1'b0;
         done1    <= 1'b0;
`ifdef ADDSUB_ARB_OVF_EN
         ovf      <= 1'b0;
`endif
      end else begin
         gnt0  <= 1'b0;
         gnt1  <= 1'b0;
         done0 <= 1'b0;
         done1 <= 1'b0;
         case (state)
            IDLE: begin
               if (req0 | req1) begin
                  state    <= EXEC;
                  cur_id   <= pick1;
                  last_gnt <= pick1;
                  cur_op   <= pick1 ? op1 : op0;
                  cur_a    <= pick1 ? a1 : a0;
                  cur_b    <= pick1 ? b1 : b0;
                  gnt0     <= ~pick1;
                  gnt1     <= pick1;
               end
            end
            EXEC: begin
               state  <= DONE;
               result <= sum[WIDTH-1:0];
               cout   <= sum[WIDTH];
               done0  <= ~cur_id;
               done1  <= cur_id;
`ifdef ADDSUB_ARB_OVF_EN
               // Overflow when the effective operands agree in sign but the result does not.
               ovf    <= (cur_a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != cur_a[WIDTH-1]);
`endif
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_addsub_arbiter.sv
// tb_addsub_arbiter: directed and randomized scoreboard bench for addsub_arbiter,
// comparing every done pulse against an arithmetic reference model.
module tb_addsub_arbiter;

   localparam int W = 32;

   typedef struct {
      logic         id;
      logic [W-1:0] res;
      logic         co;
      logic         ov;
   } exp_t;

   logic         clock = 1'b0;
   logic         clear = 1'b0;
   logic         req0 = 1'b0, req1 = 1'b0, op0 = 1'b0, op1 = 1'b0;
   logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
   logic         gnt0, gnt1, done0, done1, cout, busy;
   logic [W-1:0] result;
`ifdef ADDSUB_ARB_OVF_EN
   logic         ovf;
`endif

   int   checks = 0;
   int   failures = 0;
   exp_t sbq[$];
   logic model_last = 1'b1;
   logic last_win = 1'b0;
   logic grant_ok = 1'b0;

   addsub_arbiter #(.WIDTH(W)) dut (
      .clock (clock),
      .clear (clear),
      .req0  (req0),
      .req1  (req1),
      .op0   (op0),
      .op1   (op1),
      .a0    (a0),
      .b0    (b0),
      .a1    (a1),
      .b1    (b1),
      .gnt0  (gnt0),
      .gnt1  (gnt1),
      .done0 (done0),
      .done1 (done1),
      .result(result),
      .cout  (cout),
      .busy  (busy)
`ifdef ADDSUB_ARB_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   // Reference: plain unsigned and signed arithmetic on the captured operands.
   function automatic exp_t model(input logic id, input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t   e;
      longint sa, sb, sr, lim;
      e.id = id;
      if (!op) begin
         {e.co, e.res} = {1'b0, a} + {1'b0, b};
      end else begin
         e.res = a - b;
         e.co  = (a >= b);
      end
      sa   = $signed(a);
      sb   = $signed(b);
      sr   = op ? (sa - sb) : (sa + sb);
      lim  = longint'(1) <<< (W - 1);
      e.ov = (sr >= lim) || (sr < -lim);
      return e;
   endfunction

   function automatic logic [W-1:0] rndOperand();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return 1;
         2:       return '1;
         3:       return 32'h7FFF_FFFF;
         4:       return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic r0, input logic r1,
                                input logic o0, input logic [W-1:0] x0, input logic [W-1:0] y0,
                                input logic o1, input logic [W-1:0] x1, input logic [W-1:0] y1);
      req0 = r0; req1 = r1;
      op0 = o0; a0 = x0; b0 = y0;
      op1 = o1; a1 = x1; b1 = y1;
   endtask

   task automatic resetDut();
      @(negedge clock); #1;
      clear = 1'b0;
      applyStimulus(0, 0, 0, '0, '0, 0, '0, '0);
      repeat (2) @(negedge clock);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_result", result, 0);
      checkOutput("reset_cout", cout, 0);
      checkOutput("reset_gnt", {gnt1, gnt0}, 0);
      checkOutput("reset_done", {done1, done0}, 0);
`ifdef ADDSUB_ARB_OVF_EN
      checkOutput("reset_ovf", ovf, 0);
`endif
      #1 clear = 1'b1;
      model_last = 1'b1;
   endtask

   task automatic waitGrant();
      logic exp_win;
      logic got;
      got = 1'b0;
      exp_win = (req0 && req1) ? ~model_last : req1;
      for (int i = 0; i < 8 && !got; i++) begin
         @(negedge clock);
         got = gnt0 | gnt1;
      end
      checkOutput("grant_seen", got, 1);
      grant_ok = got;
      if (got) begin
         checkOutput("grant_id", gnt1, exp_win);
         checkOutput("grant_onehot", gnt0 & gnt1, 0);
         checkOutput("busy_exec", busy, 1);
         sbq.push_back(exp_win ? model(1'b1, op1, a1, b1) : model(1'b0, op0, a0, b0));
         model_last = exp_win;
         last_win = exp_win;
      end
   endtask

   task automatic checkDone();
      if (grant_ok) begin
         @(negedge clock);
         checkOutput("done_latency", last_win ? done1 : done0, 1);
      end
   endtask

   task automatic waitIdle();
      int n;
      n = 0;
      while (busy && n < 8) begin
         @(negedge clock);
         n++;
      end
      checkOutput("return_idle", busy, 0);
   endtask

   task automatic runOne(input logic r0, input logic r1,
                         input logic o0, input logic [W-1:0] x0, input logic [W-1:0] y0,
                         input logic o1, input logic [W-1:0] x1, input logic [W-1:0] y1,
                         input logic scramble);
      @(negedge clock); #1;
      applyStimulus(r0, r1, o0, x0, y0, o1, x1, y1);
      waitGrant();
      #1;
      req0 = 1'b0;
      req1 = 1'b0;
      if (scramble)
         applyStimulus(0, 0, $urandom_range(0, 1), rndOperand(), rndOperand(),
                       $urandom_range(0, 1), rndOperand(), rndOperand());
      checkDone();
      waitIdle();
   endtask

   // Monitor: pops the scoreboard on every done and checks result holds between dones.
   logic [W-1:0] held_res = '0;
   logic         held_co = 1'b0;
   logic         held_ov = 1'b0;

   always @(negedge clock) begin
      if (!clear) begin
         held_res = '0;
         held_co  = 1'b0;
         held_ov  = 1'b0;
      end else begin
         checks++;
         if ((gnt0 && gnt1) || (done0 && done1)) begin
            failures++;
            $display("[TB] FAIL exclusive gnt=%b%b done=%b%b required no pair", gnt1, gnt0, done1, done0);
         end
         checks++;
         if (done0 || done1) begin
            if (sbq.size() == 0) begin
               failures++;
               $display("[TB] FAIL unexpected_done done=%b%b required none", done1, done0);
            end else begin
               exp_t e;
               logic act_ov;
               e = sbq.pop_front();
               act_ov = e.ov;
`ifdef ADDSUB_ARB_OVF_EN
               act_ov = ovf;
`endif
               if (done1 !== e.id || result !== e.res || cout !== e.co || act_ov !== e.ov) begin
                  failures++;
                  $display("[TB] FAIL result id=%b res=%0h cout=%b ovf=%b required id=%b res=%0h cout=%b ovf=%b",
                           done1, result, cout, act_ov, e.id, e.res, e.co, e.ov);
               end
               held_res = e.res;
               held_co  = e.co;
               held_ov  = e.ov;
            end
         end else begin
            logic hold_ov;
            hold_ov = held_ov;
`ifdef ADDSUB_ARB_OVF_EN
            hold_ov = ovf;
`endif
            if (result !== held_res || cout !== held_co || hold_ov !== held_ov) begin
               failures++;
               $display("[TB] FAIL hold res=%0h cout=%b required res=%0h cout=%b", result, cout, held_res, held_co);
            end
         end
      end
   end

   initial begin
      resetDut();

      runOne(1, 0, 0, 32'd1, 32'd1, 0, '0, '0, 0);
      runOne(0, 1, 0, '0, '0, 1, 32'd235, 32'd35, 0);
      runOne(0, 1, 0, '0, '0, 1, 32'd20, 32'd25, 0);
      runOne(1, 0, 0, 32'hFFFF_FFFF, 32'd1, 0, '0, '0, 0);
      runOne(1, 0, 0, 32'h7FFF_FFFF, 32'd1, 0, '0, '0, 0);
      runOne(0, 1, 0, '0, '0, 0, 32'd1000, 32'd24, 1);

      // Ties held from reset alternate starting with requester 0.
      resetDut();
      @(negedge clock); #1;
      applyStimulus(1, 1, 0, 32'd5, 32'd6, 1, 32'd9, 32'd4);
      for (int r = 0; r < 3; r++) begin
         waitGrant();
         checkDone();
      end
      #1 applyStimulus(0, 0, 0, '0, '0, 0, '0, '0);
      waitIdle();

      // Clear during EXEC abandons the operation.
      @(negedge clock); #1;
      applyStimulus(1, 0, 0, 32'd77, 32'd3, 0, '0, '0);
      waitGrant();
      #1 clear = 1'b0;
      req0 = 1'b0;
      if (grant_ok) void'(sbq.pop_back());
      @(negedge clock);
      checkOutput("clear_busy", busy, 0);
      checkOutput("clear_result", result, 0);
      checkOutput("clear_cout", cout, 0);
      checkOutput("clear_done", {done1, done0}, 0);
      #1 clear = 1'b1;
      model_last = 1'b1;
      repeat (3) @(negedge clock);
      runOne(1, 0, 1, 32'd10, 32'd3, 0, '0, '0, 0);

      for (int k = 0; k < 25; k++) begin
         logic r0, r1;
         r0 = $urandom_range(0, 1);
         r1 = $urandom_range(0, 1);
         if (!r0 && !r1) r0 = 1'b1;
         runOne(r0, r1, $urandom_range(0, 1), rndOperand(), rndOperand(),
                $urandom_range(0, 1), rndOperand(), rndOperand(), $urandom_range(0, 1));
      end

      repeat (4) @(negedge clock);
      checkOutput("scoreboard_drain", sbq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
